// File: rtl/hilo_div_ctrl_if.sv
// EX-stage HI/LO bus: instruction side, divider side and HI/LO read-back.
interface hilo_div_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [63:0] div_result;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [1:0]  div_signal;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;
  logic        busy;
  logic        stall;

  modport master (
    output op_valid, op, rs_data, rt_data, div_result,
    input  div_a, div_b, div_signal, hi, lo, mf_data, busy, stall
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, div_result,
    output div_a, div_b, div_signal, hi, lo, mf_data, busy, stall
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO controller: issues DIVU to the restoring divider, captures its result,
// serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a division runs.
//
// state | meaning
// IDLE  | no division in flight; MT writes and DIVU issue accepted
// ISSUE | div_signal=00 for this one cycle; divider samples operands
// WAIT  | divider rounds counting; result captured when counter hits DIV_CYCLES
module hilo_div_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic     clk,
  input  logic     reset,
  hilo_div_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST_ROUND = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [1:0] SIG_START = 2'b00;
  localparam logic [1:0] SIG_IDLE  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state;
  logic [CW-1:0]  counter;
  logic [31:0]    hi_q;
  logic [31:0]    lo_q;
  logic [31:0]    div_a_q;
  logic [31:0]    div_b_q;
  logic [1:0]     div_signal_q;
  logic           busy_q;
  logic           hilo_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_signal_q <= SIG_IDLE;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_DIVU: begin
                div_a_q      <= bus.rs_data;
                div_b_q      <= bus.rt_data;
                div_signal_q <= SIG_START;
                busy_q       <= 1'b1;
                counter      <= '0;
                state        <= ISSUE;
              end
              OP_MTHI: hi_q <= bus.rs_data;
              OP_MTLO: lo_q <= bus.rs_data;
              default: ;
            endcase
          end
        end
        ISSUE: begin
          // Start must be dropped after one edge or the divider restarts on wrap.
          div_signal_q <= SIG_IDLE;
          counter      <= CW'(1);
          state        <= WAIT;
        end
        WAIT: begin
          if (counter == LAST_ROUND) begin
            hi_q   <= bus.div_result[63:32];
            lo_q   <= bus.div_result[31:0];
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hilo_op = 1'b0;
    case (bus.op)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101: hilo_op = 1'b1;
      default: hilo_op = 1'b0;
    endcase
  end

  // No bypass of div_result: an MF in the capture cycle stalls one extra cycle.
  assign bus.stall      = busy_q & bus.op_valid & hilo_op;
  assign bus.mf_data    = (bus.op == OP_MFHI) ? hi_q : lo_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.div_signal = div_signal_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sits in EX between the decode/ALU-control path and the 32-round unsigned restoring divider.
- Issues DIVU operations to the divider and holds the operands stable for the whole division.
- Counts the divider rounds, captures the 64-bit {remainder, quotient} result into the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO.
- Stalls the pipeline while a division is in flight.

Parameters:
- DIV_CYCLES, 32, number of divider rounds; the result is valid on div_result after this many edges following the issue edge.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- op_valid  in  1  EX-stage HI/LO-class instruction present
- op  in  3  000 NOP, 001 DIVU, 010 MFHI, 011 MFLO, 100 MTHI, 101 MTLO, 110/111 treated as NOP
- rs_data  in  32  dividend / MTHI / MTLO source
- rt_data  in  32  divisor
- div_result  in  64  divider output {remainder[63:32], quotient[31:0]}
- div_a  out  32  divider dataA
- div_b  out  32  divider dataB
- div_signal  out  2  divider Signal: 00 = start DIVU, 11 = idle
- hi  out  32  HI register
- lo  out  32  LO register
- mf_data  out  32  MFHI/MFLO read data
- busy  out  1  division in flight
- stall  out  1  hold IF/ID/EX this cycle

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - hi=0, lo=0, div_a=0, div_b=0
  - div_signal=11, busy=0, counter=0, state IDLE
- The top level ties the divider's active-high reset to ~reset, so a reset mid-division aborts both blocks together. No result is captured after a reset.
- The FSM has three states: IDLE, ISSUE, WAIT.
- IDLE:
  - On op_valid & op=DIVU at edge E0: div_a<=rs_data, div_b<=rt_data, div_signal<=00, busy<=1, counter<=0, go to ISSUE.
  - MTHI writes hi<=rs_data; MTLO writes lo<=rs_data; both take effect at that edge.
  - MFHI/MFLO: no state change.
- ISSUE (one cycle): the divider samples its operands at E1 and runs round 1. At E1: div_signal<=11, counter<=1, go to WAIT.
  - div_signal must be 00 for exactly one edge. Otherwise the divider restarts when its round count wraps to 0.
- WAIT: counter increments every edge.
  - div_a and div_b hold their values throughout.
  - When counter==DIV_CYCLES (edge E33): hi<=div_result[63:32], lo<=div_result[31:0], busy<=0, go to IDLE.
- Total latency: a DIVU accepted at E0 makes HI/LO visible after E33, i.e. 33 cycles. The first dependent MF completes in the cycle following E33.
- stall = busy & op_valid & op in {DIVU, MFHI, MFLO, MTHI, MTLO}. This is combinational.
  - A stalled instruction is not accepted; it is re-presented next cycle.
  - NOP and other ops never stall.
- During the E33 cycle busy is still 1, so an MF presented then stalls once and reads the new value in the next cycle.
- mf_data = (op==MFHI) ? hi : lo. This is combinational from the registers, with no bypass of div_result.
- Divide by zero is passed through unchanged: lo=FFFFFFFF, hi=dividend. No exception is raised.
- Operand arithmetic is unsigned 32-bit only; there is no sign handling.

Test Plan:
- Reset, then DIVU rs=100 rt=7 -> div_signal=00 for one cycle only, busy high for E0..E33; after E33 lo=14, hi=2.
- DIVU rs=0xFFFFFFFF rt=0x10 -> after 33 cycles lo=0x0FFFFFFF, hi=0xF.
- DIVU rs=1234 rt=0 -> lo=0xFFFFFFFF, hi=1234.
- MFLO issued the cycle after DIVU -> stall=1 for cycles E1..E33; the next cycle has stall=0 and mf_data equal to the new quotient. A back-to-back second DIVU is likewise held until then.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A in IDLE -> hi/lo updated at each edge with no stall; MFHI and MFLO return those values the same cycle.
- Start DIVU 100/7, pull reset low at cycle 10 for 2 cycles -> hi=lo=0, busy=0, div_signal=11; then DIVU 50/5 -> lo=10, hi=0 after 33 cycles.
